// File: rtl/display_pkg.sv
// Shared display-pipeline types: LUT channel selector, bank count and bank-swap FSM states.
package display_pkg;

    localparam int LUT_BANKS = 2;
    localparam int NUM_CH    = 3;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } lut_chan_t;

    typedef enum logic {
        SWAP_IDLE,
        SWAP_PENDING
    } swap_state_t;

endpackage

// File: rtl/color_lut_ram.sv
// One channel's colour table: two banks of 2**CH_W entries, per-bank write enables on a shared
// write port, one registered read port addressed by {bank, index}.
module color_lut_ram
    import display_pkg::*;
#(
    parameter int CH_W = 8
) (
    input  logic                 clk,
    input  logic [LUT_BANKS-1:0] wr_bank_en,
    input  logic [CH_W-1:0]      wr_addr,
    input  logic [CH_W-1:0]      wr_data,
    input  logic                 rd_en,
    input  logic                 rd_bank,
    input  logic [CH_W-1:0]      rd_addr,
    output logic [CH_W-1:0]      rd_data
);

    localparam int DEPTH = 2 ** CH_W;

    logic [CH_W-1:0] mem_q [LUT_BANKS][DEPTH];
    logic [CH_W-1:0] rd_data_q;

    // NOTE: the table array and its read register have no reset so they map onto block RAM;
    // a reset term would force the array into flops.
    always_ff @(posedge clk) begin
        if (wr_bank_en[0]) begin
            mem_q[0][wr_addr] <= wr_data;
        end
        if (wr_bank_en[1]) begin
            mem_q[1][wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_bank][rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/color_grade_lut.sv
// Per-channel RGB colour-grading LUT with double-banked tables and a tear-free swap at frame_start.
// Optional COLOR_GRADE_IDENTITY_INIT_EN: identity-fill both banks of every channel after reset.
module color_grade_lut
    import display_pkg::*;
#(
    parameter int CH_W = 8
) (
    input  logic            clk_sram,
    input  logic            rst_n_sram,
    input  logic            pix_valid,
    input  logic [CH_W-1:0] pix_red,
    input  logic [CH_W-1:0] pix_green,
    input  logic [CH_W-1:0] pix_blue,
    input  logic            frame_start,
    input  logic            grade_en,
    input  logic            lut_wr_en,
    input  logic [1:0]      lut_wr_chan,
    input  logic [CH_W-1:0] lut_wr_addr,
    input  logic [CH_W-1:0] lut_wr_data,
    input  logic            lut_commit,
    output logic            lut_wr_ready,
    output logic            swap_pending,
    output logic            swap_done,
    output logic            out_valid,
    output logic [CH_W-1:0] out_red,
    output logic [CH_W-1:0] out_green,
    output logic [CH_W-1:0] out_blue
);

`ifdef COLOR_GRADE_IDENTITY_INIT_EN
    localparam logic READY_RST  = 1'b0;
    localparam logic LOADED_RST = 1'b1;
`else
    localparam logic READY_RST  = 1'b0 ^ 1'b1;
    localparam logic LOADED_RST = 1'b0;
`endif

    swap_state_t state_q;
    logic        active_bank_q;
    logic        swap_pending_q;
    logic        swap_done_q;
    logic        lut_wr_ready_q;
    logic        lut_loaded_q;

    logic        init_busy;
    logic        init_busy_next;

`ifdef COLOR_GRADE_IDENTITY_INIT_EN
    logic [CH_W-1:0] init_cnt_q, init_cnt_d;
    logic            init_busy_q, init_busy_d;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        init_cnt_d  = init_cnt_q;
        init_busy_d = init_busy_q;
        if (init_busy_q) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == '1) begin
                init_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sram or negedge rst_n_sram) begin
        if (!rst_n_sram) begin
            init_cnt_q  <= '0;
            init_busy_q <= 1'b1;
        end else begin
            init_cnt_q  <= init_cnt_d;
            init_busy_q <= init_busy_d;
        end
    end

    assign init_busy      = init_busy_q;
    assign init_busy_next = init_busy_d;
`else
    assign init_busy      = 1'b0;
    assign init_busy_next = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sram or negedge rst_n_sram) begin
        if (!rst_n_sram) begin
            state_q        <= SWAP_IDLE;
            active_bank_q  <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            lut_wr_ready_q <= READY_RST;
            lut_loaded_q   <= LOADED_RST;
        end else begin
            swap_done_q <= 1'b0;
            unique case (state_q)
                SWAP_IDLE: begin
                    // A frame_start coinciding with the commit does not swap; the next one does.
                    if (lut_commit && lut_wr_ready_q) begin
                        state_q        <= SWAP_PENDING;
                        swap_pending_q <= 1'b1;
                        lut_wr_ready_q <= 1'b0;
                    end else begin
                        lut_wr_ready_q <= !init_busy_next;
                    end
                end
                SWAP_PENDING: begin
                    if (frame_start) begin
                        state_q        <= SWAP_IDLE;
                        active_bank_q  <= !active_bank_q;
                        swap_pending_q <= 1'b0;
                        swap_done_q    <= 1'b1;
                        lut_wr_ready_q <= 1'b1;
                        lut_loaded_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= SWAP_IDLE;
                end
            endcase
        end
    end

    logic [CH_W-1:0]      pix_in      [NUM_CH];
    logic [CH_W-1:0]      ram_rd_data [NUM_CH];
    logic [LUT_BANKS-1:0] ram_wr_bank_en [NUM_CH];
    logic [CH_W-1:0]      ram_wr_addr;
    logic [CH_W-1:0]      ram_wr_data;
    logic                 host_wr;

    assign pix_in[0] = pix_red;
    assign pix_in[1] = pix_green;
    assign pix_in[2] = pix_blue;

    assign host_wr = lut_wr_en && lut_wr_ready_q && (lut_wr_chan <= CH_B);

    // Host writes only ever touch the shadow bank; the init sweep fills both banks at once.
    always_comb begin
        ram_wr_addr = lut_wr_addr;
        ram_wr_data = lut_wr_data;
        for (int c = 0; c < NUM_CH; c++) begin
            ram_wr_bank_en[c] = '0;
            if (host_wr && (lut_wr_chan == 2'(c))) begin
                ram_wr_bank_en[c] = active_bank_q ? 2'b01 : 2'b10;
            end
        end
`ifdef COLOR_GRADE_IDENTITY_INIT_EN
        if (init_busy_q) begin
            ram_wr_addr = init_cnt_q;
            ram_wr_data = init_cnt_q;
            for (int c = 0; c < NUM_CH; c++) begin
                ram_wr_bank_en[c] = '1;
            end
        end
`endif
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ram
        color_lut_ram #(
            .CH_W (CH_W)
        ) u_ram (
            .clk        (clk_sram),
            .wr_bank_en (ram_wr_bank_en[g]),
            .wr_addr    (ram_wr_addr),
            .wr_data    (ram_wr_data),
            .rd_en      (pix_valid),
            .rd_bank    (active_bank_q),
            .rd_addr    (pix_in[g]),
            .rd_data    (ram_rd_data[g])
        );
    end

    logic            s1_valid_q,   s1_valid_d;
    logic            s1_use_lut_q, s1_use_lut_d;
    logic [CH_W-1:0] s1_byp_q [NUM_CH];
    logic [CH_W-1:0] s1_byp_d [NUM_CH];
    logic            out_valid_q,  out_valid_d;
    logic [CH_W-1:0] out_q    [NUM_CH];
    logic [CH_W-1:0] out_d    [NUM_CH];

    // Stage 1 carries the raw pixel alongside the RAM read so bypass keeps the same latency.
    always_comb begin
        s1_valid_d   = pix_valid;
        s1_use_lut_d = s1_use_lut_q;
        s1_byp_d     = s1_byp_q;
        if (pix_valid) begin
            s1_use_lut_d = grade_en && lut_loaded_q && !init_busy;
            s1_byp_d     = pix_in;
        end
    end

    always_comb begin
        out_valid_d = s1_valid_q;
        out_d       = out_q;
        if (s1_valid_q) begin
            for (int c = 0; c < NUM_CH; c++) begin
                out_d[c] = s1_use_lut_q ? ram_rd_data[c] : s1_byp_q[c];
            end
        end
    end

    always_ff @(posedge clk_sram or negedge rst_n_sram) begin
        if (!rst_n_sram) begin
            s1_valid_q   <= 1'b0;
            s1_use_lut_q <= 1'b0;
            out_valid_q  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                s1_byp_q[c] <= '0;
                out_q[c]    <= '0;
            end
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_use_lut_q <= s1_use_lut_d;
            out_valid_q  <= out_valid_d;
            s1_byp_q     <= s1_byp_d;
            out_q        <= out_d;
        end
    end

    assign lut_wr_ready = lut_wr_ready_q;
    assign swap_pending = swap_pending_q;
    assign swap_done    = swap_done_q;
    assign out_valid    = out_valid_q;
    assign out_red      = out_q[0];
    assign out_green    = out_q[1];
    assign out_blue     = out_q[2];

endmodule

// File: tb/tb_color_grade_lut.sv
// Self-checking bench for color_grade_lut: directed steps with random tables/pixels against a
// table-level reference model (banks as arrays, swap as a pending flag, 2-deep output delay).
module tb_color_grade_lut;

    localparam int CH_W = 8;

    logic       clk_sram = 1'b0;
    logic       rst_n_sram = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_red = '0, pix_green = '0, pix_blue = '0;
    logic       frame_start = 1'b0;
    logic       grade_en = 1'b0;
    logic       lut_wr_en = 1'b0;
    logic [1:0] lut_wr_chan = '0;
    logic [7:0] lut_wr_addr = '0, lut_wr_data = '0;
    logic       lut_commit = 1'b0;
    logic       lut_wr_ready, swap_pending, swap_done, out_valid;
    logic [7:0] out_red, out_green, out_blue;

    color_grade_lut #(.CH_W(CH_W)) dut (
        .clk_sram     (clk_sram),
        .rst_n_sram   (rst_n_sram),
        .pix_valid    (pix_valid),
        .pix_red      (pix_red),
        .pix_green    (pix_green),
        .pix_blue     (pix_blue),
        .frame_start  (frame_start),
        .grade_en     (grade_en),
        .lut_wr_en    (lut_wr_en),
        .lut_wr_chan  (lut_wr_chan),
        .lut_wr_addr  (lut_wr_addr),
        .lut_wr_data  (lut_wr_data),
        .lut_commit   (lut_commit),
        .lut_wr_ready (lut_wr_ready),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .out_valid    (out_valid),
        .out_red      (out_red),
        .out_green    (out_green),
        .out_blue     (out_blue)
    );

    always #5 clk_sram = ~clk_sram;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int unsigned tbl [3][2][256];
    bit          m_bank, m_pending, m_done, m_ready, m_loaded;
    int          init_left;
    bit          d1_v;
    logic [23:0] d1_rgb;
    bit          e_valid;
    logic [23:0] e_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bank = 0; m_pending = 0; m_done = 0;
        d1_v = 0; d1_rgb = '0; e_valid = 0; e_out = '0;
`ifdef COLOR_GRADE_IDENTITY_INIT_EN
        m_ready = 0; m_loaded = 1; init_left = 256;
`else
        m_ready = 1; m_loaded = 0; init_left = 0;
`endif
    endtask

    // Everything the DUT does at one rising edge, from the inputs currently applied.
    task automatic model_edge();
        logic [7:0] p [3];
        logic [7:0] r [3];
        p[0] = pix_red; p[1] = pix_green; p[2] = pix_blue;
        for (int c = 0; c < 3; c++) begin
            r[c] = (grade_en && m_loaded && init_left == 0) ? 8'(tbl[c][m_bank][p[c]]) : p[c];
        end
        e_valid = d1_v;
        if (d1_v) e_out = d1_rgb;
        d1_v = pix_valid;
        if (pix_valid) d1_rgb = {r[0], r[1], r[2]};
        if (lut_wr_en && m_ready && lut_wr_chan != 2'd3) begin
            tbl[lut_wr_chan][!m_bank][lut_wr_addr] = lut_wr_data;
        end
        if (init_left > 0) begin
            for (int c = 0; c < 3; c++) begin
                tbl[c][0][256 - init_left] = 256 - init_left;
                tbl[c][1][256 - init_left] = 256 - init_left;
            end
            init_left--;
            if (init_left == 0) m_ready = 1;
        end
        m_done = 0;
        if (!m_pending) begin
            if (lut_commit && m_ready) begin
                m_pending = 1;
                m_ready = 0;
            end
        end else if (frame_start) begin
            m_pending = 0;
            m_bank = !m_bank;
            m_done = 1;
            m_ready = 1;
            m_loaded = 1;
        end
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, e_valid);
        check("out_rgb", {out_red, out_green, out_blue}, e_out);
        check("swap_pending", swap_pending, m_pending);
        check("swap_done", swap_done, m_done);
        check("lut_wr_ready", lut_wr_ready, m_ready);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_sram);
        #1;
        check_outputs();
    endtask

    task automatic wr(input int ch, input int addr, input int data);
        lut_wr_en = 1; lut_wr_chan = 2'(ch); lut_wr_addr = 8'(addr); lut_wr_data = 8'(data);
        tick();
        lut_wr_en = 0;
    endtask

    task automatic send_pix(input int r, input int g, input int b, input bit ge);
        pix_valid = 1; pix_red = 8'(r); pix_green = 8'(g); pix_blue = 8'(b); grade_en = ge;
        tick();
        pix_valid = 0;
        repeat (3) tick();
    endtask

    task automatic commit();
        lut_commit = 1; tick(); lut_commit = 0;
    endtask

    task automatic frame();
        frame_start = 1; tick(); frame_start = 0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300; i++) begin
            if (lut_wr_ready) break;
            tick();
        end
        check("ready_wait", lut_wr_ready, 1);
    endtask

    task automatic do_reset();
        rst_n_sram = 0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk_sram);
        #1;
        rst_n_sram = 1;
    endtask

    initial begin
        int x;
        int keep;
        model_reset();

        // Reset state.
        #16;
        check_outputs();
        check("rst_out_valid", out_valid, 0);
        rst_n_sram = 1;
        wait_ready();

        // Before any swap, grading is not applied.
        send_pix(8'h21, 8'h43, 8'h65, 1);

        // 1: inverted ramp into the shadow bank, commit, swap, lookup.
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 256; i++) wr(c, i, 255 - i);
        commit();
        check("t1_pending", swap_pending, 1);
        repeat (2) tick();
        frame();
        check("t1_swap_done", swap_done, 1);
        pix_valid = 1; pix_red = 8'h12; pix_green = 8'h34; pix_blue = 8'h56; grade_en = 1;
        tick();
        pix_valid = 0;
        tick();
        check("t1_valid", out_valid, 1);
        check("t1_graded", {out_red, out_green, out_blue}, 24'hEDCBA9);
        repeat (2) tick();

        // 2: bypass with the inverted table active, then grade_en toggling per pixel.
        pix_valid = 1; pix_red = 8'h80; pix_green = 8'h01; pix_blue = 8'hFF; grade_en = 0;
        tick();
        pix_valid = 0;
        tick();
        check("t2_bypass", {out_red, out_green, out_blue}, 24'h8001FF);
        repeat (2) tick();
        for (int k = 0; k < 16; k++)
            send_pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), k[0]);

        // 3: random table into shadow, commit mid-frame, dropped write, old/new bank at the swap.
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 256; i++) wr(c, i, $urandom_range(0, 255));
        x = $urandom_range(0, 255);
        keep = int'(tbl[0][0][x]);
        send_pix(x, x, x, 1);
        commit();
        check("t3_ready_locked", lut_wr_ready, 0);
        wr(0, x, keep ^ 8'hFF);
        pix_valid = 1; frame_start = 1; pix_red = 8'(x); pix_green = 8'(x); pix_blue = 8'(x);
        tick();
        pix_valid = 0; frame_start = 0;
        tick();
        check("t3_old_bank", out_red, 255 - x);
        repeat (2) tick();
        pix_valid = 1;
        tick();
        pix_valid = 0;
        tick();
        check("t3_new_bank", out_red, keep);
        repeat (4) tick();

        // 4: commit together with frame_start, second commit ignored, swap at next frame_start.
        lut_commit = 1; frame_start = 1;
        tick();
        lut_commit = 0; frame_start = 0;
        check("t4_pending", swap_pending, 1);
        check("t4_no_swap", swap_done, 0);
        send_pix(8'h12, 8'h34, 8'h56, 1);
        commit();
        repeat (3) tick();
        frame();
        check("t4_swap_done", swap_done, 1);
        tick();
        send_pix(8'h12, 8'h34, 8'h56, 1);

        // 5: reset while a swap is pending.
        commit();
        send_pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1);
        do_reset();
        check("t5_pending_lost", swap_pending, 0);
        wait_ready();
        x = $urandom_range(0, 255);
        pix_valid = 1; pix_red = 8'(x); pix_green = 8'(x ^ 8'h33); pix_blue = 8'(255 - x);
        tick();
        pix_valid = 0;
        tick();
        check("t5_out_eq_in", {out_red, out_green, out_blue}, {8'(x), 8'(x ^ 8'h33), 8'(255 - x)});
        repeat (2) tick();
        commit();
        frame();
        send_pix(8'h12, 8'h34, 8'h56, 1);

        // 6: channel-3 writes are ignored; sweep all indices through the committed table.
        for (int k = 0; k < 8; k++) wr(3, $urandom_range(0, 255), $urandom_range(0, 255));
        commit();
        frame();
        for (int i = 0; i < 256; i++) send_pix(i, i ^ 8'h5A, 255 - i, 1);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
